// File: rtl/ec_fp2_point_add_arb.sv
// ec_fp2_point_add_arb
// Shares one in-order Fp^2 point-add engine among NUM_CH requesters.
// - Requests are granted round-robin into a registered issue stage.
// - The granted channel index is pushed into a tag FIFO.
// - Engine results return in issue order. Each one is routed to the channel
//   at the FIFO head, and the FIFO pops on the result handshake.
// Optional feature macro: EC_PADD_ARB_STATS_EN (per-channel result counters).
module ec_fp2_point_add_arb #(
   parameter type FP2_TYPE  = logic [63:0],
   parameter int  NUM_CH    = 4,
   parameter int  TAG_DEPTH = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  FP2_TYPE             i_p1 [NUM_CH],
   input  FP2_TYPE             i_p2 [NUM_CH],
   input  logic [NUM_CH-1:0]   i_val,
   output logic [NUM_CH-1:0]   o_rdy,
   output FP2_TYPE             o_p [NUM_CH],
   output logic [NUM_CH-1:0]   o_val,
   input  logic [NUM_CH-1:0]   i_rdy,
   output logic [NUM_CH-1:0]   o_err,
   output FP2_TYPE             o_pa_p1,
   output FP2_TYPE             o_pa_p2,
   output logic                o_pa_val,
   input  logic                i_pa_rdy,
   input  FP2_TYPE             i_pa_p,
   input  logic                i_pa_err,
   input  logic                i_pa_val,
   output logic                o_pa_rdy,
   output logic                o_spurious,
   output logic [15:0]         o_cnt [NUM_CH]
);

   localparam int CHW = $clog2(NUM_CH);
   localparam int AW  = $clog2(TAG_DEPTH);
   localparam int CW  = $clog2(TAG_DEPTH + 1);

   // issue stage
   logic              pa_val_q;
   FP2_TYPE           pa_p1_q, pa_p2_q;
   logic [CHW-1:0]    rr_q, rr_d;

   // tag FIFO
   logic [CHW-1:0]    tag_q [TAG_DEPTH];
   logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic              spur_q;

   logic              empty, full, slot_free;
   logic              gnt_any, push, pop;
   logic [CHW-1:0]    gnt_idx, head;
   logic [CHW:0]      idx;
   logic [NUM_CH-1:0] grant;

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == CW'(TAG_DEPTH));
   assign slot_free = !pa_val_q || i_pa_rdy;
   assign head      = tag_q[rd_q];

   // Round-robin search from rr_q. A full FIFO blocks the grant even when it pops this cycle.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      if (slot_free && !full) begin
         for (int k = 0; k < NUM_CH; k++) begin
            idx = {1'b0, rr_q} + (CHW+1)'(k);
            if (idx >= (CHW+1)'(NUM_CH)) idx = idx - (CHW+1)'(NUM_CH);
            if (!gnt_any && i_val[idx[CHW-1:0]]) begin
               gnt_any = 1'b1;
               gnt_idx = idx[CHW-1:0];
            end
         end
      end
      grant = gnt_any ? (NUM_CH'(1) << gnt_idx) : '0;
   end

   assign o_rdy = grant;
   assign push  = gnt_any;
   assign pop   = i_pa_val && !empty && i_rdy[head];

   // Only the head channel sees the engine result; the others stay quiet at zero.
   always_comb begin
      o_val = '0;
      o_err = '0;
      for (int c = 0; c < NUM_CH; c++) o_p[c] = '0;
      if (!empty) begin
         o_val[head] = i_pa_val;
         o_p[head]   = i_pa_p;
         o_err[head] = i_pa_err;
      end
   end

   // With no owner on record, a result is accepted and dropped so the engine never stalls.
   assign o_pa_rdy = empty ? i_pa_val : i_rdy[head];

   // Next-state for the FIFO pointers, occupancy and round-robin pointer.
   always_comb begin
      wr_d  = push ? wr_q + AW'(1) : wr_q;
      rd_d  = pop  ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!push && pop) cnt_d = cnt_q - CW'(1);
      rr_d  = rr_q;
      if (push) rr_d = (gnt_idx == CHW'(NUM_CH - 1)) ? '0 : gnt_idx + CHW'(1);
   end

   // Issue register: load on grant, hold while the engine stalls, drop valid once taken.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         pa_val_q <= 1'b0;
         pa_p1_q  <= '0;
         pa_p2_q  <= '0;
         rr_q     <= '0;
      end else begin
         rr_q <= rr_d;
         if (push) begin
            pa_val_q <= 1'b1;
            pa_p1_q  <= i_p1[gnt_idx];
            pa_p2_q  <= i_p2[gnt_idx];
         end else if (i_pa_rdy) begin
            pa_val_q <= 1'b0;
         end
      end
   end

   assign o_pa_val = pa_val_q;
   assign o_pa_p1  = pa_p1_q;
   assign o_pa_p2  = pa_p2_q;

   // Tag FIFO control; pointers wrap naturally at TAG_DEPTH (power of two).
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Tag storage needs no reset; entries are only read while the FIFO is not empty.
   always_ff @(posedge i_clk) begin
      if (push) tag_q[wr_q] <= gnt_idx;
   end

   // Sticky flag for results that arrive with no outstanding request.
   always_ff @(posedge i_clk) begin
      if (!i_rst)                  spur_q <= 1'b0;
      else if (i_pa_val && empty)  spur_q <= 1'b1;
   end

   assign o_spurious = spur_q;

`ifdef EC_PADD_ARB_STATS_EN
   for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
      logic [15:0] stat_q;
      // Saturating count of result handshakes delivered to this channel.
      always_ff @(posedge i_clk) begin
         if (!i_rst)
            stat_q <= '0;
         else if (pop && (head == CHW'(c)) && (stat_q != 16'hFFFF))
            stat_q <= stat_q + 16'd1;
      end
      assign o_cnt[c] = stat_q;
   end
`else
   for (genvar c = 0; c < NUM_CH; c++) begin : g_nostat
      assign o_cnt[c] = '0;
   end
`endif

endmodule

// File: tb/tb_ec_fp2_point_add_arb.sv
// Self-checking bench for ec_fp2_point_add_arb.
// The reference model keeps the outstanding owners in a queue, applies the
// round-robin rule arithmetically, and mirrors the issue register contents.
module tb_ec_fp2_point_add_arb;
   localparam int NCH = 4;
   localparam int TD  = 8;
   typedef logic [63:0] fp2_t;

   localparam fp2_t G  = 64'h0000_0000_0000_0a11;
   localparam fp2_t G2 = 64'h0000_0000_0000_2b22;
   localparam fp2_t G3 = 64'h0000_0000_0003_c333;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   fp2_t p1 [NCH];
   fp2_t p2 [NCH];
   fp2_t op [NCH];
   logic [NCH-1:0] val = '0, ordy, oval, irdy = '0, oerr;
   fp2_t pa_p1, pa_p2, pa_p = '0;
   logic pa_val_o, pa_rdy_i = 1'b0, pa_err_i = 1'b0, pa_val_i = 1'b0, pa_rdy_o, spur;
   logic [15:0] cnt [NCH];
   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ec_fp2_point_add_arb #(.FP2_TYPE(fp2_t), .NUM_CH(NCH), .TAG_DEPTH(TD)) dut (
      .i_clk(clk), .i_rst(rst_n), .i_p1(p1), .i_p2(p2), .i_val(val), .o_rdy(ordy),
      .o_p(op), .o_val(oval), .i_rdy(irdy), .o_err(oerr),
      .o_pa_p1(pa_p1), .o_pa_p2(pa_p2), .o_pa_val(pa_val_o), .i_pa_rdy(pa_rdy_i),
      .i_pa_p(pa_p), .i_pa_err(pa_err_i), .i_pa_val(pa_val_i), .o_pa_rdy(pa_rdy_o),
      .o_spurious(spur), .o_cnt(cnt));

   // ---------------- reference model ----------------
   int   mq[$];
   int   m_rr = 0;
   bit   m_pav = 0, m_spur = 0;
   fp2_t m_p1 = '0, m_p2 = '0;
   int   m_cnt [NCH];
   int   e_grant;
   logic [NCH-1:0] e_rdy, e_oval;
   logic e_pa_rdy;

   task automatic model_eval();
      int c;
      e_grant = -1;
      e_rdy   = '0;
      e_oval  = '0;
      if ((!m_pav || pa_rdy_i) && mq.size() < TD)
         for (int k = 0; k < NCH; k++) begin
            c = (m_rr + k) % NCH;
            if (e_grant < 0 && val[c]) e_grant = c;
         end
      if (e_grant >= 0) e_rdy[e_grant] = 1'b1;
      if (mq.size() == 0) e_pa_rdy = pa_val_i;
      else begin
         e_pa_rdy        = irdy[mq[0]];
         e_oval[mq[0]]   = pa_val_i;
      end
   endtask

   function automatic fp2_t exp_p(int c);
      return (mq.size() > 0 && mq[0] == c) ? pa_p : '0;
   endfunction

   function automatic logic exp_err(int c);
      return (mq.size() > 0 && mq[0] == c) ? pa_err_i : 1'b0;
   endfunction

   function automatic logic [15:0] exp_cnt(int c);
`ifdef EC_PADD_ARB_STATS_EN
      return 16'(m_cnt[c]);
`else
      return 16'(c * 0);
`endif
   endfunction

   task automatic tick();
      int h;
      model_eval();
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_rr = 0; m_pav = 0; m_p1 = '0; m_p2 = '0; m_spur = 0;
         for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      end else begin
         if (mq.size() == 0 && pa_val_i) m_spur = 1;
         if (mq.size() > 0 && pa_val_i && irdy[mq[0]]) begin
            h = mq.pop_front();
            if (m_cnt[h] < 65535) m_cnt[h]++;
         end
         if (e_grant >= 0) begin
            mq.push_back(e_grant);
            m_rr  = (e_grant + 1) % NCH;
            m_pav = 1;
            m_p1  = p1[e_grant];
            m_p2  = p2[e_grant];
         end else if (pa_rdy_i) m_pav = 0;
      end
      #1;
   endtask

   task automatic quiet_inputs();
      val = '0; irdy = '1; pa_val_i = 0; pa_rdy_i = 1; pa_err_i = 0; pa_p = '0;
   endtask

   task automatic do_reset();
      quiet_inputs();
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      quiet_inputs();
      irdy = '0; pa_rdy_i = 0;
      rst_n = 0;
      tick(); tick();
      #1;
      n_tests++; if (pa_val_o !== 1'b0) begin n_fail++; $display("FAIL reset_pa_val got %0b exp 0", pa_val_o); end
      n_tests++; if (pa_p1 !== '0 || pa_p2 !== '0) begin n_fail++; $display("FAIL reset_pa_p got %0h/%0h exp 0/0", pa_p1, pa_p2); end
      n_tests++; if (spur !== 1'b0) begin n_fail++; $display("FAIL reset_spur got %0b exp 0", spur); end
      n_tests++; if (ordy !== '0 || oval !== '0 || pa_rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset_hs got rdy=%b val=%b pa_rdy=%b exp 0", ordy, oval, pa_rdy_o); end
      for (int c = 0; c < NCH; c++) begin
         n_tests++; if (cnt[c] !== 16'd0) begin n_fail++; $display("FAIL reset_cnt%0d got %0d exp 0", c, cnt[c]); end
      end
      rst_n = 1;
   endtask

   task automatic test_single();
      logic [15:0] want;
      do_reset();
      p1[2] = G; p2[2] = G2; val = 4'b0100;
      #1;
      n_tests++; if (ordy !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b exp 0100", ordy); end
      tick();
      val = '0;
      #1;
      n_tests++; if (pa_val_o !== 1'b1 || pa_p1 !== G || pa_p2 !== G2) begin n_fail++; $display("FAIL single_issue got v=%b %0h/%0h exp 1 %0h/%0h", pa_val_o, pa_p1, pa_p2, G, G2); end
      tick();
      pa_val_i = 1; pa_p = G3;
      #1;
      n_tests++; if (oval !== 4'b0100 || op[2] !== G3 || op[0] !== '0) begin n_fail++; $display("FAIL single_result got val=%b p2=%0h p0=%0h exp 0100 %0h 0", oval, op[2], op[0], G3); end
      n_tests++; if (pa_rdy_o !== 1'b1) begin n_fail++; $display("FAIL single_pa_rdy got %b exp 1", pa_rdy_o); end
      tick();
      pa_val_i = 0;
      #1;
`ifdef EC_PADD_ARB_STATS_EN
      want = 16'd1;
`else
      want = 16'd0;
`endif
      n_tests++; if (cnt[2] !== want) begin n_fail++; $display("FAIL single_cnt got %0d exp %0d", cnt[2], want); end
      n_tests++; if (oval !== '0 || spur !== 1'b0) begin n_fail++; $display("FAIL single_idle got val=%b spur=%b exp 0 0", oval, spur); end
   endtask

   task automatic test_rr();
      logic [NCH-1:0] want;
      do_reset();
      val = '1;
      for (int i = 0; i < 2 * NCH; i++) begin
         #1;
         want = NCH'(1 << (i % NCH));
         n_tests++; if (ordy !== want) begin n_fail++; $display("FAIL rr_grant%0d got %b exp %b", i, ordy, want); end
         tick();
      end
      val = '0;
      for (int i = 0; i < 2 * NCH; i++) begin
         pa_val_i = 1; pa_p = {$urandom, $urandom};
         #1;
         want = NCH'(1 << (i % NCH));
         n_tests++; if (oval !== want || op[i % NCH] !== pa_p) begin n_fail++; $display("FAIL rr_result%0d got %b %0h exp %b %0h", i, oval, op[i % NCH], want, pa_p); end
         tick();
      end
      pa_val_i = 0;
   endtask

   task automatic test_stall();
      fp2_t hold;
      logic [NCH-1:0] want;
      int guard;
      do_reset();
      for (int c = 0; c < NCH; c++) begin p1[c] = {$urandom, $urandom}; p2[c] = {$urandom, $urandom}; end
      val = '1; pa_rdy_i = 0;
      #1;
      n_tests++; if (ordy !== 4'b0001) begin n_fail++; $display("FAIL stall_first got %b exp 0001", ordy); end
      hold = p1[0];
      tick();
      for (int i = 0; i < 20; i++) begin
         p1[0] = {$urandom, $urandom};
         #1;
         n_tests++; if (ordy !== '0 || pa_val_o !== 1'b1 || pa_p1 !== hold) begin n_fail++; $display("FAIL stall_hold%0d got rdy=%b v=%b p1=%0h exp 0 1 %0h", i, ordy, pa_val_o, pa_p1, hold); end
         tick();
      end
      pa_rdy_i = 1;
      for (int i = 0; i < TD - 1; i++) begin
         #1;
         want = NCH'(1 << ((i + 1) % NCH));
         n_tests++; if (ordy !== want) begin n_fail++; $display("FAIL stall_fill%0d got %b exp %b", i, ordy, want); end
         tick();
      end
      #1;
      n_tests++; if (ordy !== '0) begin n_fail++; $display("FAIL full_block got %b exp 0", ordy); end
      tick();
      pa_val_i = 1;
      #1;
      n_tests++; if (ordy !== '0 || pa_rdy_o !== 1'b1 || oval !== 4'b0001) begin n_fail++; $display("FAIL full_pop_nogrant got rdy=%b pa_rdy=%b val=%b exp 0 1 0001", ordy, pa_rdy_o, oval); end
      tick();
      pa_val_i = 0;
      #1;
      n_tests++; if (ordy !== 4'b0001) begin n_fail++; $display("FAIL after_pop_grant got %b exp 0001", ordy); end
      tick();
      val = '0; pa_val_i = 1;
      guard = 0;
      while (mq.size() > 0 && guard < 4 * TD) begin tick(); guard++; end
      n_tests++; if (mq.size() != 0) begin n_fail++; $display("FAIL stall_drain left %0d exp 0", mq.size()); end
      pa_val_i = 0;
   endtask

   task automatic test_hold();
      do_reset();
      val = 4'b0010;
      tick();
      val = '0;
      tick();
      pa_val_i = 1; pa_p = {$urandom, $urandom}; irdy = 4'b1101;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_tests++; if (oval !== 4'b0010 || pa_rdy_o !== 1'b0) begin n_fail++; $display("FAIL hold%0d got val=%b pa_rdy=%b exp 0010 0", i, oval, pa_rdy_o); end
         tick();
      end
      irdy = '1;
      #1;
      n_tests++; if (oval !== 4'b0010 || pa_rdy_o !== 1'b1 || op[1] !== pa_p) begin n_fail++; $display("FAIL hold_release got val=%b pa_rdy=%b p=%0h exp 0010 1 %0h", oval, pa_rdy_o, op[1], pa_p); end
      tick();
      pa_val_i = 0;
      #1;
      n_tests++; if (oval !== '0 || pa_rdy_o !== 1'b0 || spur !== 1'b0) begin n_fail++; $display("FAIL hold_single_pop got val=%b pa_rdy=%b spur=%b exp 0 0 0", oval, pa_rdy_o, spur); end
   endtask

   task automatic test_spurious();
      do_reset();
      pa_val_i = 1; pa_p = {$urandom, $urandom};
      #1;
      n_tests++; if (pa_rdy_o !== 1'b1 || oval !== '0) begin n_fail++; $display("FAIL spur_accept got pa_rdy=%b val=%b exp 1 0", pa_rdy_o, oval); end
      tick();
      pa_val_i = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++; if (spur !== 1'b1) begin n_fail++; $display("FAIL spur_sticky%0d got %b exp 1", i, spur); end
         tick();
      end
      rst_n = 0;
      tick();
      #1;
      n_tests++; if (spur !== 1'b0) begin n_fail++; $display("FAIL spur_clear got %b exp 0", spur); end
      rst_n = 1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      val = 4'b0111;
      tick(); tick(); tick();
      val = '0;
      rst_n = 0;
      tick();
      rst_n = 1;
      #1;
      n_tests++; if (pa_val_o !== 1'b0 || pa_rdy_o !== 1'b0 || oval !== '0) begin n_fail++; $display("FAIL mid_reset got v=%b pa_rdy=%b val=%b exp 0 0 0", pa_val_o, pa_rdy_o, oval); end
      val = '1;
      #1;
      n_tests++; if (ordy !== 4'b0001) begin n_fail++; $display("FAIL mid_rr got %b exp 0001", ordy); end
      val = '0; pa_val_i = 1;
      #1;
      n_tests++; if (pa_rdy_o !== 1'b1) begin n_fail++; $display("FAIL mid_drop got %b exp 1", pa_rdy_o); end
      tick();
      pa_val_i = 0;
      #1;
      n_tests++; if (spur !== 1'b1) begin n_fail++; $display("FAIL mid_spur got %b exp 1", spur); end
   endtask

   task automatic test_random();
      do_reset();
      for (int cyc = 0; cyc < 500; cyc++) begin
         rst_n    = ($urandom_range(0, 79) != 0);
         val      = NCH'($urandom);
         irdy     = NCH'($urandom) | NCH'($urandom);
         pa_rdy_i = ($urandom_range(0, 3) != 0);
         pa_val_i = 1'($urandom);
         pa_err_i = 1'($urandom);
         pa_p     = {$urandom, $urandom};
         for (int c = 0; c < NCH; c++) begin p1[c] = {$urandom, $urandom}; p2[c] = {$urandom, $urandom}; end
         #1;
         model_eval();
         n_tests++; if (ordy !== e_rdy) begin n_fail++; $display("FAIL rnd_rdy c%0d got %b exp %b", cyc, ordy, e_rdy); end
         n_tests++; if (oval !== e_oval) begin n_fail++; $display("FAIL rnd_val c%0d got %b exp %b", cyc, oval, e_oval); end
         n_tests++; if (pa_rdy_o !== e_pa_rdy) begin n_fail++; $display("FAIL rnd_pa_rdy c%0d got %b exp %b", cyc, pa_rdy_o, e_pa_rdy); end
         n_tests++; if (pa_val_o !== m_pav || pa_p1 !== m_p1 || pa_p2 !== m_p2) begin n_fail++; $display("FAIL rnd_issue c%0d got %b %0h/%0h exp %b %0h/%0h", cyc, pa_val_o, pa_p1, pa_p2, m_pav, m_p1, m_p2); end
         n_tests++; if (spur !== m_spur) begin n_fail++; $display("FAIL rnd_spur c%0d got %b exp %b", cyc, spur, m_spur); end
         for (int c = 0; c < NCH; c++) begin
            n_tests++; if (op[c] !== exp_p(c) || oerr[c] !== exp_err(c) || cnt[c] !== exp_cnt(c)) begin
               n_fail++; $display("FAIL rnd_ch%0d c%0d got p=%0h e=%b n=%0d exp p=%0h e=%b n=%0d", c, cyc, op[c], oerr[c], cnt[c], exp_p(c), exp_err(c), exp_cnt(c));
            end
         end
         tick();
      end
      rst_n = 1;
   endtask

   initial begin
      for (int c = 0; c < NCH; c++) begin p1[c] = '0; p2[c] = '0; m_cnt[c] = 0; end
      test_reset();
      test_single();
      test_rr();
      test_stall();
      test_hold();
      test_spurious();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
